aes_round_ctrl: RTL

// - Iterative AES-128 encryption sequencer. Owns state, round-key and round-counter registers.
// - Drives one shared round datapath (sub_bytes -> shift_rows -> mix_col -> add_round_key) once per cycle.
// - Drives one external combinational key-expansion step the same way.
// - Upstream side is a valid/ready input port; downstream side is a valid/ready output port holding the ciphertext.

---
 rtl/aes_round_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 sequencer around an external round
// datapath and key-expansion step. Optional pre-layer: CAESAR_LAYER_EN.
module aes_round_ctrl #(
  parameter int NR       = 10,
  parameter int CAESAR_K = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic         rnd_last,
  input  logic [127:0] rnd_out,
  output logic [127:0] key_cur,
  output logic [7:0]   rcon,
  input  logic [127:0] key_next,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } st_t;

`ifdef CAESAR_LAYER_EN
  localparam bit CAESAR_ON = 1'b1;
`else
  localparam bit CAESAR_ON = 1'b0;
`endif

  localparam logic [7:0] PT_SHIFT =
    CAESAR_ON ? 8'(CAESAR_K) : 8'h00;

  st_t          st;
  logic [3:0]   round_cnt;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] pre_pt;

  function automatic logic [7:0] xtime(
    input logic [7:0] r
  );
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Per-byte plaintext shift, no carry between bytes.
  always_comb begin
    pre_pt = '0;
    for (int i = 0; i < 16; i++)
      pre_pt[8*i +: 8] = pt[8*i +: 8] + PT_SHIFT;
  end

  assign in_ready  = (st == IDLE) & ~rst;
  assign rnd_state = state_reg;
  assign key_cur   = key_reg;
  assign rnd_key   = key_next;
  assign rnd_last  = (st == ROUND) &&
                     (round_cnt == 4'(NR));

  // Sequencer: accept, iterate NR rounds, hold ct until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      round_cnt <= '0;
      state_reg <= '0;
      key_reg   <= '0;
      ct        <= '0;
      rcon      <= 8'h01;
      out_valid <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            state_reg <= pre_pt ^ key;
            key_reg   <= key;
            round_cnt <= 4'd1;
            rcon      <= 8'h01;
            st        <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= rnd_out;
          key_reg   <= key_next;
          rcon      <= xtime(rcon);
          round_cnt <= round_cnt + 4'd1;
          if (rnd_last) begin
            ct        <= rnd_out;
            out_valid <= 1'b1;
            st        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
